// File: rtl/cpu_ad48_csr_file.sv
// CSR responder for the cpu_ad48 core: STATUS, SCRATCH, CYCLE, INSTRET plus priv_mode.
// Optional privilege checking is enabled by defining CPU_AD48_CSR_PRIV_CHECK_EN.
module cpu_ad48_csr_file #(
   parameter int          XLEN         = 48,
   parameter logic [11:0] ADDR_STATUS  = 12'h000,
   parameter logic [11:0] ADDR_SCRATCH = 12'h001,
   parameter logic [11:0] ADDR_CYCLE   = 12'hC00,
   parameter logic [11:0] ADDR_INSTRET = 12'hC02
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_func,
   input  logic [11:0]     req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err,
   input  logic            retire,
   output logic [1:0]      priv_mode,
   output logic [XLEN-1:0] csr_status,
   output logic [XLEN-1:0] csr_scratch,
   output logic [XLEN-1:0] csr_cycle,
   output logic [XLEN-1:0] csr_instret
);

   localparam logic [1:0] FUNC_R  = 2'd0;
   localparam logic [1:0] FUNC_RW = 2'd1;
   localparam logic [1:0] FUNC_RS = 2'd2;
   localparam logic [1:0] FUNC_RC = 2'd3;

   typedef enum logic {S_IDLE, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   status_q, status_d;
   logic [XLEN-1:0]   scratch_q, scratch_d;
   logic [XLEN-1:0]   cycle_q, cycle_d;
   logic [XLEN-1:0]   instret_q, instret_d;
   logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   logic              accept;
   logic              hit_status, hit_scratch, hit_cycle, hit_instret;
   logic              known, is_write, priv_fault, illegal;
   logic [XLEN-1:0]   old_val, new_val;

   function automatic logic [XLEN-1:0] wr_value(input logic [1:0]      func,
                                                input logic [XLEN-1:0] old,
                                                input logic [XLEN-1:0] wdata);
      case (func)
         FUNC_RW: wr_value = wdata;
         FUNC_RS: wr_value = old | wdata;
         FUNC_RC: wr_value = old & ~wdata;
         default: wr_value = old;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      status_d    = status_q;
      scratch_d   = scratch_q;
      cycle_d     = cycle_q + XLEN'(1);
      instret_d   = instret_q + XLEN'(retire);
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      // In RESP the slot frees up exactly when the consumer takes the response.
      req_ready   = (state_q == S_IDLE) || rsp_ready;
      accept      = req_valid && req_ready;

      hit_status  = (req_addr == ADDR_STATUS);
      hit_scratch = (req_addr == ADDR_SCRATCH);
      hit_cycle   = (req_addr == ADDR_CYCLE);
      hit_instret = (req_addr == ADDR_INSTRET);
      known       = hit_status || hit_scratch || hit_cycle || hit_instret;
      is_write    = (req_func != FUNC_R);

`ifdef CPU_AD48_CSR_PRIV_CHECK_EN
      priv_fault  = (status_q[1:0] < req_addr[9:8]);
`else
      priv_fault  = 1'b0;
`endif

      illegal = !known || (is_write && (hit_cycle || hit_instret)) || priv_fault;

      old_val = '0;
      if (hit_status)  old_val = status_q;
      if (hit_scratch) old_val = scratch_q;
      if (hit_cycle)   old_val = cycle_q;
      if (hit_instret) old_val = instret_q;

      new_val = wr_value(req_func, old_val, req_wdata);

      if (accept) begin
         state_d     = S_RESP;
         rsp_err_d   = illegal;
         rsp_rdata_d = illegal ? '0 : old_val;
         if (!illegal && is_write) begin
            // WARL: the reserved privilege encoding 2'b10 leaves the field untouched.
            if (hit_status)
               status_d = {new_val[XLEN-1:2],
                           (new_val[1:0] == 2'b10) ? status_q[1:0] : new_val[1:0]};
            if (hit_scratch)
               scratch_d = new_val;
         end
      end else if ((state_q == S_RESP) && rsp_ready) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         status_q    <= XLEN'(3);
         scratch_q   <= '0;
         cycle_q     <= '0;
         instret_q   <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         status_q    <= status_d;
         scratch_q   <= scratch_d;
         cycle_q     <= cycle_d;
         instret_q   <= instret_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign priv_mode   = status_q[1:0];
   assign csr_status  = status_q;
   assign csr_scratch = scratch_q;
   assign csr_cycle   = cycle_q;
   assign csr_instret = instret_q;

endmodule

// File: tb/tb_cpu_ad48_csr_file.sv
// Directed self-checking bench for cpu_ad48_csr_file; define CPU_AD48_CSR_PRIV_CHECK_EN to add the privilege scenario.
module tb_cpu_ad48_csr_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_func;
   logic [11:0] req_addr;
   logic [47:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [47:0] rsp_rdata;
   logic        rsp_err;
   logic        retire;
   logic [1:0]  priv_mode;
   logic [47:0] csr_status, csr_scratch, csr_cycle, csr_instret;

   int n_checks = 0;
   int n_fail   = 0;

   cpu_ad48_csr_file dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .retire(retire), .priv_mode(priv_mode),
      .csr_status(csr_status), .csr_scratch(csr_scratch),
      .csr_cycle(csr_cycle), .csr_instret(csr_instret)
   );

   always #5 clk = ~clk;

   // Offer one request from a falling edge; returns the response seen just after the accepting edge.
   task automatic issue(input logic [1:0] f, input logic [11:0] a, input logic [47:0] w,
                        output logic [47:0] rd, output logic e, output logic v);
      int waited = 0;
      @(negedge clk);
      req_valid = 1'b1; req_func = f; req_addr = a; req_wdata = w;
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         n_checks++; n_fail++;
         $display("FAIL issue_timeout: req_ready=%0b required 1", req_ready);
      end
      @(posedge clk); #1;
      rd = rsp_rdata; e = rsp_err; v = rsp_valid;
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [47:0] rd; logic e, v;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %0b exp 1", req_ready); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %0b exp 0", rsp_valid); end
      n_checks++; if (rsp_rdata !== 48'h0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp: got %h/%0b exp 0/0", rsp_rdata, rsp_err); end
      n_checks++; if (csr_scratch !== 48'h0 || csr_instret !== 48'h0) begin n_fail++; $display("FAIL rst_regs: scratch %h instret %h exp 0", csr_scratch, csr_instret); end
      issue(2'd0, 12'h000, 48'h0, rd, e, v);
      n_checks++; if (v !== 1'b1 || rd !== 48'h3 || e !== 1'b0) begin n_fail++; $display("FAIL rst_read_status: got v%0b %h e%0b exp v1 3 e0", v, rd, e); end
      n_checks++; if (priv_mode !== 2'b11) begin n_fail++; $display("FAIL rst_priv: got %b exp 11", priv_mode); end
   endtask

   task automatic test_retire();
      logic [47:0] rd; logic e, v;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk); retire = 1'b1;
      end
      @(negedge clk); retire = 1'b0;
      n_checks++; if (csr_instret !== 48'd15) begin n_fail++; $display("FAIL instret_tap: got %0d exp 15", csr_instret); end
      n_checks++; if (csr_cycle < 48'd15) begin n_fail++; $display("FAIL cycle_min: got %0d exp >=15", csr_cycle); end
      issue(2'd0, 12'hC02, 48'h0, rd, e, v);
      n_checks++; if (rd !== 48'd15 || e !== 1'b0) begin n_fail++; $display("FAIL instret_read: got %0d e%0b exp 15 e0", rd, e); end
   endtask

   task automatic test_scratch();
      logic [47:0] rd; logic e, v;
      issue(2'd1, 12'h001, 48'h12340, rd, e, v);
      n_checks++; if (rd !== 48'h0 || e !== 1'b0) begin n_fail++; $display("FAIL rw_scratch: got %h e%0b exp 0 e0", rd, e); end
      issue(2'd2, 12'h001, 48'hF, rd, e, v);
      n_checks++; if (rd !== 48'h12340) begin n_fail++; $display("FAIL rs_scratch: got %h exp 12340", rd); end
      issue(2'd0, 12'h001, 48'h0, rd, e, v);
      n_checks++; if (rd !== 48'h1234F) begin n_fail++; $display("FAIL r_scratch: got %h exp 1234f", rd); end
      issue(2'd3, 12'h001, 48'hF, rd, e, v);
      n_checks++; if (rd !== 48'h1234F) begin n_fail++; $display("FAIL rc_scratch: got %h exp 1234f", rd); end
      n_checks++; if (csr_scratch !== 48'h12340) begin n_fail++; $display("FAIL scratch_final: got %h exp 12340", csr_scratch); end
   endtask

   task automatic test_illegal();
      logic [47:0] rd; logic e, v;
      logic [47:0] c0;
      issue(2'd1, 12'h3FF, 48'hABC, rd, e, v);
      n_checks++; if (e !== 1'b1 || rd !== 48'h0) begin n_fail++; $display("FAIL bad_addr: got %h e%0b exp 0 e1", rd, e); end
      n_checks++; if (csr_scratch !== 48'h12340 || csr_status !== 48'h3) begin n_fail++; $display("FAIL bad_addr_state: scratch %h status %h exp 12340/3", csr_scratch, csr_status); end
      issue(2'd1, 12'hC00, 48'h5, rd, e, v);
      n_checks++; if (e !== 1'b1 || rd !== 48'h0) begin n_fail++; $display("FAIL rw_cycle: got %h e%0b exp 0 e1", rd, e); end
      c0 = csr_cycle;
      @(posedge clk); #1;
      n_checks++; if (csr_cycle !== c0 + 48'd1) begin n_fail++; $display("FAIL cycle_counting: got %0d exp %0d", csr_cycle, c0 + 48'd1); end
   endtask

   task automatic test_cycle_spacing();
      logic [47:0] r1, r2; logic e, v;
      issue(2'd0, 12'hC00, 48'h0, r1, e, v);
      repeat (2) @(posedge clk);
      issue(2'd0, 12'hC00, 48'h0, r2, e, v);
      n_checks++; if (r2 !== r1 + 48'd3 || e !== 1'b0) begin n_fail++; $display("FAIL cycle_delta: got %0d exp %0d", r2, r1 + 48'd3); end
   endtask

   task automatic test_warl();
      logic [47:0] rd; logic e, v;
      issue(2'd1, 12'h000, 48'h123002, rd, e, v);
      n_checks++; if (rd !== 48'h3) begin n_fail++; $display("FAIL warl_old: got %h exp 3", rd); end
      n_checks++; if (csr_status !== 48'h123003 || priv_mode !== 2'b11) begin n_fail++; $display("FAIL warl_status: got %h priv %b exp 123003 11", csr_status, priv_mode); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      req_valid = 1'b1; req_func = 2'd1; req_addr = 12'h001; req_wdata = 48'hA;
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 48'h12340) begin n_fail++; $display("FAIL b2b_0: got v%0b %h exp v1 12340", rsp_valid, rsp_rdata); end
      req_wdata = 48'hB;
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 48'hA) begin n_fail++; $display("FAIL b2b_1: got v%0b %h exp v1 a", rsp_valid, rsp_rdata); end
      req_func = 2'd0;
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 48'hB) begin n_fail++; $display("FAIL b2b_2: got v%0b %h exp v1 b", rsp_valid, rsp_rdata); end
      req_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: rsp_valid %0b exp 0", rsp_valid); end
   endtask

   task automatic test_stall();
      logic [47:0] rd; logic e, v;
      @(negedge clk); rsp_ready = 1'b0;
      issue(2'd0, 12'h001, 48'h0, rd, e, v);
      n_checks++; if (v !== 1'b1 || rd !== 48'hB) begin n_fail++; $display("FAIL stall_first: got v%0b %h exp v1 b", v, rd); end
      req_valid = 1'b1; req_func = 2'd1; req_addr = 12'h001; req_wdata = 48'hDEAD;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 48'hB || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold%0d: v%0b %h e%0b rdy%0b exp v1 b e0 rdy0", i, rsp_valid, rsp_rdata, rsp_err, req_ready);
         end
      end
      n_checks++; if (csr_scratch !== 48'hB) begin n_fail++; $display("FAIL stall_ignored: scratch %h exp b", csr_scratch); end
      @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: rsp_valid %0b exp 0", rsp_valid); end
   endtask

   task automatic test_reset_mid();
      logic [47:0] rd; logic e, v;
      @(negedge clk); rsp_ready = 1'b0;
      issue(2'd1, 12'h001, 48'h55, rd, e, v);
      n_checks++; if (v !== 1'b1 || csr_scratch !== 48'h55) begin n_fail++; $display("FAIL mid_pre: v%0b scratch %h exp v1 55", v, csr_scratch); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b0 || csr_scratch !== 48'h0 || csr_status !== 48'h3) begin n_fail++; $display("FAIL mid_reset: v%0b scratch %h status %h exp v0 0 3", rsp_valid, csr_scratch, csr_status); end
      @(negedge clk); rst = 1'b0; rsp_ready = 1'b1;
   endtask

`ifdef CPU_AD48_CSR_PRIV_CHECK_EN
   task automatic test_priv();
      logic [47:0] rd; logic e, v;
      issue(2'd1, 12'h000, 48'h0, rd, e, v);
      n_checks++; if (e !== 1'b0 || priv_mode !== 2'b00) begin n_fail++; $display("FAIL priv_drop: e%0b priv %b exp e0 00", e, priv_mode); end
      issue(2'd0, 12'h300, 48'h0, rd, e, v);
      n_checks++; if (e !== 1'b1 || rd !== 48'h0) begin n_fail++; $display("FAIL priv_fault: got %h e%0b exp 0 e1", rd, e); end
   endtask
`endif

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_func = 2'd0; req_addr = 12'h0; req_wdata = 48'h0;
      rsp_ready = 1'b1; retire = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      test_reset();
      test_retire();
      test_scratch();
      test_illegal();
      test_cycle_spacing();
      test_warl();
      test_back_to_back();
      test_stall();
      test_reset_mid();
`ifdef CPU_AD48_CSR_PRIV_CHECK_EN
      test_priv();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
